// File: rtl/keyed_lookup_table_if.sv
`default_nettype none
// ============================================================================
// Module      : keyed_lookup_table_if
// Description : Request/response handshake bundle for keyed_lookup_table.
//               The i_/o_ names are given from the table's point of view.
//               slave  modport : the lookup table
//               master modport : the requester
//   i_req_valid / o_req_ready / i_req_key            : lookup request
//   o_rsp_valid / i_rsp_ready / o_rsp_data /
//   o_rsp_hit   / o_rsp_idx                          : registered response
// Revision    : 1.0 - initial release
// ============================================================================
interface keyed_lookup_table_if #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 32
);
  localparam int c_IDX_W = $clog2(NR_KEY);

  logic                i_req_valid;
  logic                o_req_ready;
  logic [KEY_LEN-1:0]  i_req_key;
  logic                o_rsp_valid;
  logic                i_rsp_ready;
  logic [DATA_LEN-1:0] o_rsp_data;
  logic                o_rsp_hit;
  logic [c_IDX_W-1:0]  o_rsp_idx;

  modport slave (
    input  i_req_valid, i_req_key, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_hit, o_rsp_idx
  );

  modport master (
    output i_req_valid, i_req_key, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_hit, o_rsp_idx
  );
endinterface
`default_nettype wire

// File: rtl/keyed_lookup_table.sv
`default_nettype none
// ============================================================================
// Module      : keyed_lookup_table
// Description : Small flop-based associative table. Each entry holds a key,
//               data word and valid bit. A lookup request compares its key
//               against all valid entries; the lowest-index match wins, and a
//               miss returns the default data. The result is registered one
//               cycle after acceptance in a single output stage that supports
//               full throughput under valid/ready backpressure.
// Ports       : i_clk, i_rst_n           - clock, async active-low reset
//               i_wr_*                   - table entry write port
//               i_flush                  - clear all entry valid bits
//               i_default_data           - data returned on a miss
//               bus (slave)              - request/response handshake
//               o_hit_cnt, o_miss_cnt    - lookup statistics (optional)
// Options     : define KEYED_LOOKUP_STAT_EN to add saturating hit/miss
//               counters and their output ports.
// Revision    : 1.0 - initial release
// ============================================================================
module keyed_lookup_table #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 32
) (
  input  wire logic                      i_clk,
  input  wire logic                      i_rst_n,
  input  wire logic                      i_wr_en,
  input  wire logic [$clog2(NR_KEY)-1:0] i_wr_idx,
  input  wire logic [KEY_LEN-1:0]        i_wr_key,
  input  wire logic [DATA_LEN-1:0]       i_wr_data,
  input  wire logic                      i_wr_vld,
  input  wire logic                      i_flush,
  input  wire logic [DATA_LEN-1:0]       i_default_data,
`ifdef KEYED_LOOKUP_STAT_EN
  output logic [31:0]                    o_hit_cnt,
  output logic [31:0]                    o_miss_cnt,
`endif
  keyed_lookup_table_if.slave            bus
);

  localparam int c_IDX_W = $clog2(NR_KEY);

  // Table storage
  logic [KEY_LEN-1:0]  r_key  [NR_KEY];
  logic [DATA_LEN-1:0] r_data [NR_KEY];
  logic [NR_KEY-1:0]   r_vld;

  // Response register
  logic                r_rsp_valid;
  logic [DATA_LEN-1:0] r_rsp_data;
  logic                r_rsp_hit;
  logic [c_IDX_W-1:0]  r_rsp_idx;

  // Lookup result against the pre-edge table contents
  logic                w_hit;
  logic [c_IDX_W-1:0]  w_idx;
  logic [DATA_LEN-1:0] w_data;
  logic                w_req_ready;
  logic                w_accept;

  assign w_req_ready = !r_rsp_valid || bus.i_rsp_ready;
  assign w_accept    = bus.i_req_valid && w_req_ready;

  assign bus.o_req_ready = w_req_ready;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_data  = r_rsp_data;
  assign bus.o_rsp_hit   = r_rsp_hit;
  assign bus.o_rsp_idx   = r_rsp_idx;

  // Scan from the top index down so the lowest matching index is the one
  // left standing when the loop finishes.
  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_data = i_default_data;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (r_vld[i] && (r_key[i] == bus.i_req_key)) begin
        w_hit  = 1'b1;
        w_idx  = c_IDX_W'(i);
        w_data = r_data[i];
      end
    end
  end

  // Key/data payload needs no reset: nothing reads it while its valid bit
  // is clear.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_key[i_wr_idx]  <= i_wr_key;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  // Flush wins over a write landing in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
    end else if (i_flush) begin
      r_vld <= '0;
    end else if (i_wr_en) begin
      r_vld[i_wr_idx] <= i_wr_vld;
    end
  end

  // Payload only moves on acceptance, so a stalled or drained response keeps
  // its contents and later table writes cannot disturb it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_idx   <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_data;
      r_rsp_hit   <= w_hit;
      r_rsp_idx   <= w_hit ? w_idx : '0;
    end else if (bus.i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef KEYED_LOOKUP_STAT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        w_cnt_hit;
  logic        w_cnt_miss;

  assign w_cnt_hit  = w_accept &&  w_hit;
  assign w_cnt_miss = w_accept && !w_hit;

  // On flush the counters restart from zero, but the request accepted in the
  // flush cycle still counts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (i_flush) begin
      r_hit_cnt  <= {31'd0, w_cnt_hit};
      r_miss_cnt <= {31'd0, w_cnt_miss};
    end else begin
      if (w_cnt_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_cnt_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/keyed_lookup_table.md
KEYED_LOOKUP_TABLE -- requirements
Module: keyed_lookup_table

Interface
REQ-001 SHALL have parameter NR_KEY, default 4, number of table entries (>=2).
REQ-002 SHALL have parameter KEY_LEN, default 2, key width in bits.
REQ-003 SHALL have parameter DATA_LEN, default 32, data width in bits.
REQ-004 SHALL have ports: i_clk input 1, the single clock; i_rst_n input 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports: i_wr_en input 1, table write strobe; i_wr_idx input $clog2(NR_KEY), entry index; i_wr_key input KEY_LEN, key; i_wr_data input DATA_LEN, data; i_wr_vld input 1, entry valid bit to store.
REQ-006 SHALL have port i_flush input 1, which clears all entry valid bits.
REQ-007 SHALL have port i_default_data input DATA_LEN, returned on a miss.
REQ-008 SHALL have ports: i_req_valid input 1, lookup request; o_req_ready output 1, request accept; i_req_key input KEY_LEN, lookup key.
REQ-009 SHALL have ports: o_rsp_valid output 1; i_rsp_ready input 1; o_rsp_data output DATA_LEN; o_rsp_hit output 1; o_rsp_idx output $clog2(NR_KEY), matching entry.

Function
REQ-010 SHALL hold NR_KEY entries, each with a key, data and a valid bit, stored in flops.
REQ-011 SHALL write the addressed entry with i_wr_key, i_wr_data and i_wr_vld on a rising edge when i_wr_en=1.
REQ-012 SHALL, when i_flush=1, clear every valid bit at the edge, taking priority over a simultaneous write; key/data contents are don't-care.
REQ-013 SHALL accept a request when i_req_valid && o_req_ready.
REQ-014 SHALL drive o_req_ready = !o_rsp_valid || i_rsp_ready (single output register, full throughput).
REQ-015 SHALL register the result one cycle after acceptance: hit = some valid entry key equals i_req_key.
REQ-016 SHALL, on multiple matches, select the lowest-index matching entry.
REQ-017 SHALL, on a miss, return o_rsp_hit=0, o_rsp_data=i_default_data sampled at acceptance, and o_rsp_idx=0.
REQ-018 SHALL match against table contents before the edge, so a write or flush in the acceptance cycle is not visible to that request.
REQ-019 SHALL hold o_rsp_valid, o_rsp_data, o_rsp_hit and o_rsp_idx stable while o_rsp_valid && !i_rsp_ready.
REQ-020 SHALL clear o_rsp_valid when the response is taken and no new request is accepted in the same cycle.
REQ-021 SHALL NOT let later table writes alter a response already registered.

Reset
REQ-022 SHALL, on i_rst_n=0 asynchronously, clear all entry valid bits and set o_rsp_valid=0, o_rsp_hit=0, o_rsp_data=0 and o_rsp_idx=0.
REQ-023 SHALL drive o_req_ready=1 from the first edge after reset release.
REQ-024 SHALL discard any in-flight response if reset is asserted mid-operation.

Configuration
REQ-025 SHALL, with macro KEYED_LOOKUP_STAT_EN defined, add outputs o_hit_cnt [31:0] and o_miss_cnt [31:0].
REQ-026 SHALL increment these counters once per accepted request according to its outcome, saturating at 32'hFFFF_FFFF.
REQ-027 SHALL clear the counters on reset and on i_flush, with the flush cycle's own request still counted after the clear.
REQ-028 SHALL, without KEYED_LOOKUP_STAT_EN, omit the counters and their ports entirely, with all other behaviour identical.

Verification
REQ-029 Scenario: write idx2 key=2'b10 data=32'hCAFE vld=1; request key 2'b10 -> next cycle o_rsp_valid=1, o_rsp_hit=1, o_rsp_idx=2, o_rsp_data=32'hCAFE.
REQ-030 Scenario: empty table, i_default_data=32'hDEAD, request key 2'b01 -> o_rsp_hit=0, o_rsp_data=32'hDEAD, o_rsp_idx=0.
REQ-031 Scenario: idx1 and idx3 both key 2'b11 with data 32'h11 and 32'h33; request 2'b11 -> o_rsp_idx=1, o_rsp_data=32'h11.
REQ-032 Scenario: i_rsp_ready=0 for 3 cycles with a response pending -> outputs stable and o_req_ready=0; release ready -> back-to-back requests return one response per cycle.
REQ-033 Scenario: i_flush and a write to idx0 in the same cycle as a request hitting idx0 -> that response hits; the next request to the same key misses.
REQ-034 Scenario: with KEYED_LOOKUP_STAT_EN, 5 hits and 2 misses -> o_hit_cnt=5, o_miss_cnt=2; assert i_rst_n=0 mid-stream -> counters and o_rsp_valid go to 0 immediately.
